// File: rtl/usr_pkg.sv
// usr_pkg: shared definitions for the universal shift register.
//   - MODE_* : 3-bit command encodings (6 and 7 are reserved and act as HOLD)
//   - state_t: controller FSM states
//   - cnt_w  : width needed to express a shift count of 0..width
//   - mode_is_shift: true for the four single-bit step modes
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHR  = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_ROR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_LOAD = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Count must be able to hold WIDTH itself so a full-word shift is expressible.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic logic mode_is_shift(input logic [2:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL) ||
           (mode == MODE_ROR) || (mode == MODE_ROL);
  endfunction

endpackage

// File: rtl/usr_step.sv
// usr_step: purely combinational single-step next-Q function.
//   q          - current register word
//   mode       - latched command (only the shift/rotate codes move bits)
//   ser_in_msb - bit entering q[WIDTH-1] on SHR
//   ser_in_lsb - bit entering q[0] on SHL
//   next_q     - word after one step; any non-shift mode passes q through
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             ser_in_msb,
  input  logic             ser_in_lsb,
  output logic [WIDTH-1:0] next_q
);

  always_comb begin
    next_q = q;
    case (mode)
      MODE_SHR: next_q = {ser_in_msb, q[WIDTH-1:1]};
      MODE_SHL: next_q = {q[WIDTH-2:0], ser_in_lsb};
      MODE_ROR: next_q = {q[0], q[WIDTH-1:1]};
      MODE_ROL: next_q = {q[WIDTH-2:0], q[WIDTH-1]};
      default:  next_q = q;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit universal shift register with a counted-burst
// controller. One command per accepted Start: LOAD, HOLD, or a burst of Count
// single-bit shifts/rotates. Done pulses for one cycle when a command finishes.
//   CLK         - clock, rising edge
//   Reset       - synchronous, active-low
//   Start       - command strobe, accepted when not Busy
//   Mode        - 0 HOLD, 1 SHR, 2 SHL, 3 ROR, 4 ROL, 5 LOAD, 6-7 as HOLD
//   Count       - number of steps for shift/rotate modes
//   Par_in      - parallel load data
//   Ser_in_msb  - bit shifted into the MSB on SHR (sampled each step)
//   Ser_in_lsb  - bit shifted into the LSB on SHL (sampled each step)
//   Par_out     - register contents Q
//   Shift_out_r - Q[0]
//   Shift_out_l - Q[WIDTH-1]
//   Busy        - high while a burst is stepping
//   Done        - one-cycle completion pulse
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Mode,
  input  logic [CNT_W-1:0] Count,
  input  logic [WIDTH-1:0] Par_in,
  input  logic             Ser_in_msb,
  input  logic             Ser_in_lsb,
  output logic [WIDTH-1:0] Par_out,
  output logic             Shift_out_r,
  output logic             Shift_out_l,
  output logic             Busy,
  output logic             Done
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q, step_q;
  logic [CNT_W-1:0] rem;
  logic [2:0]       mode_q;
  logic             accept, burst;

  // Start is honoured in IDLE and DONE; DONE acceptance gives back-to-back
  // commands with no idle bubble.
  assign accept = Start && (state != ST_SHIFT);
  // A command only enters SHIFT if it really moves bits.
  assign burst  = mode_is_shift(Mode) && (Count != '0);

  usr_step #(.WIDTH(WIDTH)) u_step (
    .q          (q),
    .mode       (mode_q),
    .ser_in_msb (Ser_in_msb),
    .ser_in_lsb (Ser_in_lsb),
    .next_q     (step_q)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) state_nxt = burst ? ST_SHIFT : ST_DONE;
        else        state_nxt = ST_IDLE;
      end
      ST_SHIFT: state_nxt = (rem == CNT_W'(1)) ? ST_DONE : ST_SHIFT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    Busy = (state == ST_SHIFT);
    Done = (state == ST_DONE);
  end

  // Datapath: Q, remaining count and latched mode
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      q      <= '0;
      rem    <= '0;
      mode_q <= MODE_HOLD;
    end else if (accept) begin
      mode_q <= Mode;
      rem    <= burst ? Count : '0;
      if (Mode == MODE_LOAD) q <= Par_in;
    end else if (state == ST_SHIFT) begin
      q   <= step_q;
      rem <= rem - CNT_W'(1);
    end
  end

  assign Par_out     = q;
  assign Shift_out_r = q[0];
  assign Shift_out_l = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             Reset = 1'b0;
  logic             Start = 1'b0;
  logic [2:0]       Mode = 3'd0;
  logic [CNT_W-1:0] Count = '0;
  logic [WIDTH-1:0] Par_in = '0;
  logic             Ser_in_msb = 1'b0;
  logic             Ser_in_lsb = 1'b0;
  logic [WIDTH-1:0] Par_out;
  logic             Shift_out_r, Shift_out_l, Busy, Done;

  int total = 0;
  int bad   = 0;

  universal_shift_reg #(.WIDTH(WIDTH)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .Start       (Start),
    .Mode        (Mode),
    .Count       (Count),
    .Par_in      (Par_in),
    .Ser_in_msb  (Ser_in_msb),
    .Ser_in_lsb  (Ser_in_lsb),
    .Par_out     (Par_out),
    .Shift_out_r (Shift_out_r),
    .Shift_out_l (Shift_out_l),
    .Busy        (Busy),
    .Done        (Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs/outputs are handled 1ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a command for one accepting edge.
  task automatic issue(input logic [2:0] m, input logic [3:0] c, input logic [7:0] p);
    Mode = m; Count = c; Par_in = p; Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic load(input logic [7:0] p);
    issue(3'd5, 4'd0, p);
    tick();
  endtask

  logic [3:0] shr_out = 4'b0101;      // bit i = Shift_out_r before step i
  logic [7:0] shl_bits = 8'b01001101; // bit i = Ser_in_lsb for step i

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_q", Par_out, 8'h00);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    Reset = 1'b1;

    // Reset mid-burst: SHR by 5 on 0xFF, reset after 2 steps
    load(8'hFF);
    issue(3'd1, 4'd5, 8'h00);
    tick(); tick();
    chk("mid_busy", Busy, 1'b1);
    chk("mid_q", Par_out, 8'h3F);
    Reset = 1'b0;
    tick();
    chk("mrst_q", Par_out, 8'h00);
    chk("mrst_busy", Busy, 1'b0);
    chk("mrst_done", Done, 1'b0);
    Reset = 1'b1;
    tick();
    chk("mrst_nodone", Done, 1'b0);
    chk("mrst_idle", Busy, 1'b0);

    // LOAD 0xA5
    issue(3'd5, 4'd0, 8'hA5);
    chk("ld_done", Done, 1'b1);
    chk("ld_q", Par_out, 8'hA5);
    chk("ld_busy", Busy, 1'b0);
    tick();
    chk("ld_done_drop", Done, 1'b0);

    // SHR by 4 with Ser_in_msb=1
    Ser_in_msb = 1'b1;
    issue(3'd1, 4'd4, 8'h00);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("shr_busy%0d", i), Busy, 1'b1);
      chk($sformatf("shr_out%0d", i), Shift_out_r, shr_out[i]);
      chk($sformatf("shr_nodone%0d", i), Done, 1'b0);
      tick();
    end
    chk("shr_q", Par_out, 8'hFA);
    chk("shr_done", Done, 1'b1);
    chk("shr_busy_end", Busy, 1'b0);
    tick();
    chk("shr_done_drop", Done, 1'b0);
    Ser_in_msb = 1'b0;

    // ROL by 8 is identity
    load(8'h3C);
    issue(3'd4, 4'd8, 8'h00);
    repeat (8) tick();
    chk("rol8_q", Par_out, 8'h3C);
    chk("rol8_done", Done, 1'b1);
    tick();

    // ROR by 3 on 0x81
    load(8'h81);
    chk("ror_outl", Shift_out_l, 1'b1);
    issue(3'd3, 4'd3, 8'h00);
    repeat (3) tick();
    chk("ror3_q", Par_out, 8'h30);
    chk("ror3_done", Done, 1'b1);
    tick();

    // SHL by 8 with live serial input
    load(8'h00);
    issue(3'd2, 4'd8, 8'h00);
    for (int i = 0; i < 8; i++) begin
      Ser_in_lsb = shl_bits[i];
      tick();
    end
    chk("shl_q", Par_out, 8'hB2);
    chk("shl_done", Done, 1'b1);
    Ser_in_lsb = 1'b0;
    tick();

    // Boundary commands: Count=0 SHL, HOLD, reserved Mode 7
    load(8'h5A);
    issue(3'd2, 4'd0, 8'hFF);
    chk("c0_done", Done, 1'b1);
    chk("c0_busy", Busy, 1'b0);
    chk("c0_q", Par_out, 8'h5A);
    tick();
    issue(3'd0, 4'd3, 8'hFF);
    chk("hold_done", Done, 1'b1);
    chk("hold_busy", Busy, 1'b0);
    chk("hold_q", Par_out, 8'h5A);
    tick();
    issue(3'd7, 4'd3, 8'hFF);
    chk("m7_done", Done, 1'b1);
    chk("m7_busy", Busy, 1'b0);
    chk("m7_q", Par_out, 8'h5A);
    tick();
    chk("m7_idle", Done, 1'b0);

    // Start during SHIFT is ignored
    load(8'h01);
    issue(3'd4, 4'd3, 8'h00);
    tick();
    Mode = 3'd5; Par_in = 8'hFF; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("ign_busy", Busy, 1'b1);
    tick();
    chk("ign_q", Par_out, 8'h08);
    chk("ign_done", Done, 1'b1);
    tick();
    chk("ign_noq", Par_out, 8'h08);
    chk("ign_nodone", Done, 1'b0);
    chk("ign_nobusy", Busy, 1'b0);

    // Back-to-back: ROR by 2 then LOAD 0x55 with Start held
    Mode = 3'd3; Count = 4'd2; Start = 1'b1;
    tick();
    Mode = 3'd5; Par_in = 8'h55;
    chk("b2b_busy", Busy, 1'b1);
    tick();
    tick();
    chk("b2b_done1", Done, 1'b1);
    chk("b2b_q1", Par_out, 8'h02);
    tick();
    Start = 1'b0;
    chk("b2b_done2", Done, 1'b1);
    chk("b2b_q2", Par_out, 8'h55);
    tick();
    chk("b2b_end", Done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal shift register with a counted-burst controller. It holds a WIDTH-bit word and performs one command per Start: parallel load, hold, or a burst of Count logical or rotating shifts in either direction. Completion is reported with a Done pulse. It sits in the serial I/O path as the general-purpose replacement for fixed 4-bit right-shift registers, serving SPI-style serialisers, deserialisers and barrel-by-steps shifts.

## Interface
- WIDTH, 8, data word width; legal range ≥ 2.
- CNT_W, $clog2(WIDTH+1), width of Count; a full-word shift is always expressible.
- CLK  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- Start  in  1  command strobe; accepted only when Busy=0.
- Mode  in  3  command: 0 HOLD, 1 SHR, 2 SHL, 3 ROR, 4 ROL, 5 LOAD, 6–7 reserved (behave as HOLD).
- Count  in  CNT_W  number of single-bit steps for shift/rotate modes; ignored for LOAD/HOLD.
- Par_in  in  WIDTH  parallel load data.
- Ser_in_msb  in  1  bit entering Q[WIDTH-1] on SHR.
- Ser_in_lsb  in  1  bit entering Q[0] on SHL.
- Par_out  out  WIDTH  register contents Q.
- Shift_out_r  out  1  Q[0], the bit leaving on SHR.
- Shift_out_l  out  1  Q[WIDTH-1], the bit leaving on SHL.
- Busy  out  1  high while a burst is in progress.
- Done  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset (Reset=0 at an edge) forces IDLE, Q=0, internal remaining-count=0, Busy=0, Done=0. Reset overrides any state, including mid-burst.
- A Start sampled in IDLE or DONE is accepted. Mode and Count are latched at that edge. Start during SHIFT is ignored (not queued).
- Behaviour at the accepting edge:
  - LOAD: Q<=Par_in, next state DONE.
  - HOLD, a reserved code, or Count=0: Q unchanged, next state DONE.
  - Otherwise: Q unchanged, rem<=Count, next state SHIFT.
- SHIFT: each edge performs one step using the latched mode and rem<=rem-1. When rem==1 at the edge, next state is DONE; otherwise the FSM stays in SHIFT.
  - SHR: Q<={Ser_in_msb, Q[W-1:1]}.
  - SHL: Q<={Q[W-2:0], Ser_in_lsb}.
  - ROR: Q<={Q[0], Q[W-1:1]}.
  - ROL: Q<={Q[W-2:0], Q[W-1]}.
- Serial inputs are sampled live at each step edge, not latched at Start.
- DONE: Done=1 for exactly one cycle. Next state is IDLE, or the accept path if Start=1.
- Count > WIDTH is legal: steps simply continue. For example, ROR by WIDTH returns the original word.
- Busy = (state==SHIFT). Done = (state==DONE). Both are decoded from registered state, with no combinational path from inputs.
- Par_out and the serial outputs follow Q directly.

## Timing
- Burst of k≥1 steps accepted at edge E0: steps occur at edges E0+1 … E0+k. Busy is high in cycles E0..E0+k-1, measured after each edge. Done is high in the cycle following edge E0+k.
- LOAD, HOLD or k=0 accepted at E0: Q updates at E0 (LOAD only), and Done is high in the cycle after E0. Busy never rises.
- Back-to-back commands: Start held during the DONE cycle is accepted at the DONE→next edge, with no idle bubble. Minimum period for a k-step burst is k+1 cycles.
- Reset released at edge R (Reset=1 at R): a Start at R is accepted normally.

## Structure
- Shared package usr_pkg holds:
  - the mode encoding constants (MODE_HOLD … MODE_LOAD);
  - the FSM state enum;
  - a width function for CNT_W.
- One natural sub-module, usr_step: a purely combinational one-step next-Q function. It takes (Q, mode, Ser_in_msb, Ser_in_lsb) and produces next Q. The top level owns the FSM, rem counter and Q register.

## Test plan
- Reset: drive activity, assert Reset=0 mid-SHIFT (WIDTH=8, Count=5, after 2 steps) -> next edge Q=0x00, Busy=0, Done=0, state IDLE; no Done pulse appears.
- LOAD then SHR: LOAD 0xA5 -> Done after 1 cycle, Par_out=0xA5. Then SHR Count=4, Ser_in_msb=1 -> after 4 steps Q=0xFA, Shift_out_r sequence 1,0,1,0, Done one cycle after the 4th step.
- Rotate identity: LOAD 0x3C, ROL Count=8 -> Q=0x3C; ROR Count=3 on 0x81 -> Q=0x30.
- SHL with live serial input: Q=0x00, SHL Count=8, Ser_in_lsb toggling 1,0,1,1,0,0,1,0 per step -> Q=0xB2.
- Boundary commands: Count=0 SHL, HOLD, and Mode=7 -> Q unchanged, Busy never high, Done in the next cycle. Start pulsed during SHIFT -> ignored; total steps equal the original Count.
- Back-to-back: Start held high across DONE with LOAD 0x55 following ROR Count=2 -> second command accepted on the DONE edge, Done pulses in two consecutive bursts with no idle cycle.
